// File: rtl/pc_fetch_if.sv
// Fetch-queue bundle: instruction-memory handshake, core-facing head entry and redirect.
// master = fetch queue, slave = the memory/core side driving it.
interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        deq;
  logic        instr_vld;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_vld, instr, instr_pc,
    input  imem_ack, imem_rdata, deq, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_vld, instr, instr_pc,
    output imem_ack, imem_rdata, deq, redirect, redirect_pc
  );
endinterface

// File: rtl/pc_fetch_queue.sv
// Instruction-fetch front end: owns the PC, fetches over req/ack and buffers {pc, word}
// in a DEPTH-entry FIFO. Optional FETCH_STATS_EN adds stall/fetch counters.
module pc_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_fetch_if.master  bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_stall,
  output logic [31:0] stat_fetch
`endif
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state;
  logic        req;
  logic [31:0] pc;
  logic [31:0] addr;
  logic        discard;
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr;
  logic [AW:0] count;
  logic        vld;
  logic        push;
  logic        pop;
  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_pc    [DEPTH];

  assign count = wr_ptr - rd_ptr;
  assign vld   = (count != '0);
  assign push  = (state == REQ) && bus.imem_ack && !discard && !bus.redirect;
  assign pop   = bus.deq && vld && !bus.redirect;

  assign bus.imem_req  = req;
  assign bus.imem_addr = addr;
  assign bus.instr_vld = vld;
  assign bus.instr     = vld ? mem_instr[rd_ptr[AW-1:0]] : '0;
  assign bus.instr_pc  = vld ? mem_pc[rd_ptr[AW-1:0]]    : '0;

  // A request is only issued while IDLE, so count alone covers the in-flight slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req     <= 1'b0;
      pc      <= PC_RESET;
      addr    <= PC_RESET;
      discard <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.redirect) begin
            pc <= bus.redirect_pc;
          end else if (count < DEPTH_W) begin
            state <= REQ;
            req   <= 1'b1;
            addr  <= pc;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            state   <= IDLE;
            req     <= 1'b0;
            discard <= 1'b0;
            if (bus.redirect) begin
              pc <= bus.redirect_pc;
            end else if (!discard) begin
              pc <= pc + PC_STEP;
            end
          end else if (bus.redirect) begin
            // Keep the outstanding request intact; its response is dropped on arrival.
            pc      <= bus.redirect_pc;
            discard <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (bus.redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr[AW-1:0]] <= bus.imem_rdata;
      mem_pc[wr_ptr[AW-1:0]]    <= pc;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall <= '0;
      stat_fetch <= '0;
    end else begin
      if (!vld && !bus.redirect && (stat_stall != '1)) begin
        stat_stall <= stat_stall + 32'd1;
      end
      if (push && (stat_fetch != '1)) begin
        stat_fetch <= stat_fetch + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_pc_fetch_queue.sv
// Self-checking bench for pc_fetch_queue: scenario tasks plus a randomized run checked
// against a queue-based reference model of the fetch stream.
module tb_pc_fetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_fetch_if f ();
  pc_fetch_if w ();

`ifdef FETCH_STATS_EN
  logic [31:0] stall0, fetch0, stall1, fetch1;
`endif

  pc_fetch_queue #(.DEPTH(DEPTH), .PC_RESET(32'h0), .PC_STEP(32'd4)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(f)
`ifdef FETCH_STATS_EN
    , .stat_stall(stall0), .stat_fetch(fetch0)
`endif
  );

  // Second instance exercising PC wrap; its memory acks in the request cycle.
  pc_fetch_queue #(.DEPTH(DEPTH), .PC_RESET(32'hFFFF_FFF8), .PC_STEP(32'd4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus(w)
`ifdef FETCH_STATS_EN
    , .stat_stall(stall1), .stat_fetch(fetch1)
`endif
  );

  assign w.imem_ack    = w.imem_req;
  assign w.imem_rdata  = ~w.imem_addr;
  assign w.deq         = 1'b1;
  assign w.redirect    = 1'b0;
  assign w.redirect_pc = '0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mpc;
  bit          mdisc;
  int unsigned mstall, mfetch;
  int          n_checks = 0;
  int          n_err = 0;

  bit          mem_auto, man_ack;
  int          lat_min, lat_max, lat_left;
  bit          pend;
  logic [31:0] held;
  bit          g_ack, g_start;
  logic [31:0] g_addr;

  function automatic void model_clear();
    q.delete();
    mpc = 32'h0; mdisc = 0; mstall = 0; mfetch = 0;
    pend = 0; lat_left = -1; g_ack = 0; g_start = 0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    f.imem_ack = 0; f.imem_rdata = '0; f.deq = 0; f.redirect = 0; f.redirect_pc = '0;
    mem_auto = 1; man_ack = 0; lat_min = 1; lat_max = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // One clock: drive inputs and the memory at the negedge, check outputs against the
  // model, advance the model through the coming posedge.
  task automatic step(input bit d, input bit r, input logic [31:0] rpc);
    bit   push;
    ent_t e;
    f.deq = d; f.redirect = r; f.redirect_pc = rpc;
    f.imem_ack = 1'b0;
    f.imem_rdata = $urandom();
    if (mem_auto) begin
      if (f.imem_req) begin
        if (lat_left < 0) lat_left = $urandom_range(lat_max, lat_min);
        if (lat_left == 0) begin
          f.imem_ack = 1'b1;
          lat_left = -1;
        end else begin
          lat_left--;
        end
      end
    end else begin
      f.imem_ack = man_ack;
    end

    n_checks++;
    if (f.instr_vld !== (q.size() != 0)) begin
      n_err++;
      $display("FAIL instr_vld @%0t: got %b exp %b", $time, f.instr_vld, q.size() != 0);
    end
    if (q.size() != 0) begin
      n_checks++;
      if (f.instr !== q[0].ins || f.instr_pc !== q[0].pc) begin
        n_err++;
        $display("FAIL head @%0t: got pc=%h ins=%h exp pc=%h ins=%h",
                 $time, f.instr_pc, f.instr, q[0].pc, q[0].ins);
      end
    end
`ifdef FETCH_STATS_EN
    n_checks++;
    if (stall0 !== mstall || fetch0 !== mfetch) begin
      n_err++;
      $display("FAIL stats @%0t: got stall=%0d fetch=%0d exp stall=%0d fetch=%0d",
               $time, stall0, fetch0, mstall, mfetch);
    end
`endif
    g_start = f.imem_req && !pend;
    g_ack   = f.imem_req && f.imem_ack;
    g_addr  = f.imem_addr;
    if (f.imem_req) begin
      n_checks++;
      if (pend) begin
        if (f.imem_addr !== held) begin
          n_err++;
          $display("FAIL addr_stable @%0t: got %h exp %h", $time, f.imem_addr, held);
        end
      end else if (f.imem_addr !== mpc || q.size() >= DEPTH) begin
        n_err++;
        $display("FAIL req_start @%0t: got addr=%h occ=%0d exp addr=%h occ<%0d",
                 $time, f.imem_addr, q.size(), mpc, DEPTH);
      end
      held = f.imem_addr;
    end
    pend = f.imem_req && !f.imem_ack;

    push = f.imem_req && f.imem_ack;
    if (q.size() == 0 && !r) mstall++;
    if (r) begin
      q.delete();
      mpc = rpc;
      mdisc = f.imem_req && !f.imem_ack;
    end else begin
      if (d && q.size() != 0) void'(q.pop_front());
      if (push) begin
        if (mdisc) begin
          mdisc = 0;
        end else begin
          e.pc = mpc; e.ins = f.imem_rdata;
          q.push_back(e);
          mpc += 32'd4;
          mfetch++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_req_start(input string tag);
    g_start = 0;
    for (int c = 0; c < 10 && !g_start; c++) step(1'b0, 1'b0, '0);
    n_checks++;
    if (!g_start) begin
      n_err++;
      $display("FAIL %s_timeout: got no request exp request within 10 cycles", tag);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (f.imem_req !== 1'b0 || f.instr_vld !== 1'b0 || f.instr !== '0 || f.instr_pc !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b vld=%b instr=%h pc=%h exp all 0",
               f.imem_req, f.instr_vld, f.instr, f.instr_pc);
    end
`ifdef FETCH_STATS_EN
    n_checks++;
    if (stall0 !== '0 || fetch0 !== '0) begin
      n_err++;
      $display("FAIL reset_stats: got %0d/%0d exp 0/0", stall0, fetch0);
    end
`endif
  endtask

  task automatic test_fetch_order();
    logic [31:0] exp_a [4];
    int nreq = 0;
    bit seen_ack = 0;
    exp_a = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    for (int c = 0; c < 40 && nreq < 4; c++) begin
      step(1'b0, 1'b0, '0);
      if (g_start) begin
        n_checks++;
        if (g_addr !== exp_a[nreq]) begin
          n_err++;
          $display("FAIL order_addr%0d: got %h exp %h", nreq, g_addr, exp_a[nreq]);
        end
        nreq++;
      end
      if (g_ack && !seen_ack) begin
        seen_ack = 1;
        n_checks++;
        if (f.instr_vld !== 1'b1 || f.instr_pc !== 32'h0) begin
          n_err++;
          $display("FAIL first_visible: got vld=%b pc=%h exp vld=1 pc=0", f.instr_vld, f.instr_pc);
        end
      end
    end
    n_checks++;
    if (nreq != 4) begin
      n_err++;
      $display("FAIL order_count: got %0d requests exp 4", nreq);
    end
  endtask

  task automatic test_full_stall();
    int nacks = 0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      step(1'b0, 1'b0, '0);
      if (g_ack) nacks++;
    end
    n_checks++;
    if (nacks != 4 || f.imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL full_stall: got acks=%0d req=%b exp acks=4 req=0", nacks, f.imem_req);
    end
    step(1'b1, 1'b0, '0);
    wait_req_start("refill");
    n_checks++;
    if (g_addr !== 32'h10) begin
      n_err++;
      $display("FAIL refill_addr: got %h exp 00000010", g_addr);
    end
  endtask

  // Continues from test_full_stall: 3 entries held, request for 0x10 outstanding.
  task automatic test_deq_ack_full();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h8, 32'hC, 32'h10, 32'h14};
    mem_auto = 0; man_ack = 0;
    step(1'b0, 1'b0, '0);
    man_ack = 1;
    step(1'b1, 1'b0, '0);
    man_ack = 0;
    n_checks++;
    if (f.instr_vld !== 1'b1 || f.instr_pc !== 32'h8) begin
      n_err++;
      $display("FAIL deq_ack_head: got vld=%b pc=%h exp vld=1 pc=8", f.instr_vld, f.instr_pc);
    end
    mem_auto = 1; lat_left = -1;
    for (int c = 0; c < 12; c++) step(1'b0, 1'b0, '0);
    n_checks++;
    if (f.imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL refull_req: got req=%b exp 0", f.imem_req);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (f.instr_pc !== exp_pc[i]) begin
        n_err++;
        $display("FAIL drain%0d: got pc=%h exp %h", i, f.instr_pc, exp_pc[i]);
      end
      step(1'b1, 1'b0, '0);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    mem_auto = 0;
    for (int k = 0; k < 2; k++) begin
      man_ack = 0;
      wait_req_start("pre_redirect");
      man_ack = 1;
      step(1'b0, 1'b0, '0);
    end
    man_ack = 0;
    wait_req_start("stale_req");
    step(1'b1, 1'b1, 32'h100);
    n_checks++;
    if (f.instr_vld !== 1'b0 || f.imem_req !== 1'b1 || f.imem_addr !== 32'h8) begin
      n_err++;
      $display("FAIL redirect_flush: got vld=%b req=%b addr=%h exp vld=0 req=1 addr=8",
               f.instr_vld, f.imem_req, f.imem_addr);
    end
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    man_ack = 1;
    step(1'b0, 1'b0, '0);
    man_ack = 0;
    n_checks++;
    if (f.instr_vld !== 1'b0) begin
      n_err++;
      $display("FAIL stale_drop: got vld=%b exp 0", f.instr_vld);
    end
    mem_auto = 1; lat_left = -1; lat_min = 0; lat_max = 2;
    wait_req_start("post_redirect");
    n_checks++;
    if (g_addr !== 32'h100) begin
      n_err++;
      $display("FAIL redirect_addr: got %h exp 00000100", g_addr);
    end
    for (int c = 0; c < 10 && f.instr_vld !== 1'b1; c++) step(1'b0, 1'b0, '0);
    n_checks++;
    if (f.instr_vld !== 1'b1 || f.instr_pc !== 32'h100) begin
      n_err++;
      $display("FAIL redirect_entry: got vld=%b pc=%h exp vld=1 pc=00000100", f.instr_vld, f.instr_pc);
    end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp_a [3];
    int n = 0;
    exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    do_reset();
    for (int c = 0; c < 30 && n < 3; c++) begin
      if (w.imem_req) begin
        n_checks++;
        if (w.imem_addr !== exp_a[n]) begin
          n_err++;
          $display("FAIL wrap_addr%0d: got %h exp %h", n, w.imem_addr, exp_a[n]);
        end
        n++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (n != 3) begin
      n_err++;
      $display("FAIL wrap_count: got %0d requests exp 3", n);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_auto = 0; man_ack = 0;
    wait_req_start("pre_reset");
    step(1'b0, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    f.imem_ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if (f.imem_req !== 1'b0 || f.instr_vld !== 1'b0) begin
      n_err++;
      $display("FAIL in_reset: got req=%b vld=%b exp 0/0", f.imem_req, f.instr_vld);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
`ifdef FETCH_STATS_EN
    n_checks++;
    if (stall0 !== '0 || fetch0 !== '0) begin
      n_err++;
      $display("FAIL midreset_stats: got %0d/%0d exp 0/0", stall0, fetch0);
    end
`endif
    man_ack = 1;
    step(1'b0, 1'b0, '0);
    man_ack = 0;
    n_checks++;
    if (f.instr_vld !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_ack: got vld=%b exp 0", f.instr_vld);
    end
    mem_auto = 1; lat_left = -1;
    wait_req_start("post_reset");
    n_checks++;
    if (g_addr !== 32'h0) begin
      n_err++;
      $display("FAIL post_reset_addr: got %h exp 00000000", g_addr);
    end
  endtask

  task automatic test_random();
    int nacks = 0;
    int deq_pct;
    do_reset();
    lat_min = 0; lat_max = 3;
    for (int c = 0; c < 1500; c++) begin
      deq_pct = ((c / 250) % 2 == 0) ? 30 : 85;
      step($urandom_range(99, 0) < deq_pct, $urandom_range(29, 0) == 0,
           $urandom() & 32'hFFFF_FFFC);
      if (g_ack) nacks++;
    end
    n_checks++;
    if (nacks < 100) begin
      n_err++;
      $display("FAIL random_progress: got %0d acks exp >= 100", nacks);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_order();
    test_full_stall();
    test_deq_ack_full();
    test_redirect();
    test_pc_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
